seg_capture: RTL

Sequential decoder and monitor for the seven-segment interface driven by the `updown` counter. It samples `seg`/`digit` and accepts a glyph only after it has been stable for a programmable number of cycles. It decodes the accepted glyph back to a 4-bit hex value and classifies each change as an up-step, down-step or jump. It sits on the display side of the counter and gives the counter's output a self-checking consumer for bring-up and regression.

---
 rtl/seg_capture_if.sv | 31 +++
 rtl/seg_capture.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seg_capture_if.sv
// Seven-segment capture bus: raw display inputs
// plus the decoded value and step-event outputs.
interface seg_capture_if #(
   parameter int CNT_W = 8
);
   logic [6:0]       seg;
   logic             digit;
   logic [3:0]       value;
   logic             valid;
   logic             update;
   logic             step_up;
   logic             step_down;
   logic             jump;
   logic             bad_glyph;
   logic [CNT_W-1:0] up_cnt;
   logic [CNT_W-1:0] down_cnt;

   modport master (
      output seg, digit,
      input  value, valid, update,
      input  step_up, step_down, jump,
      input  bad_glyph, up_cnt, down_cnt
   );

   modport slave (
      input  seg, digit,
      output value, valid, update,
      output step_up, step_down, jump,
      output bad_glyph, up_cnt, down_cnt
   );
endinterface

// File: rtl/seg_capture.sv
// Debounced seven-segment glyph capture, hex decode
// and up/down/jump classification of value changes.
module seg_capture #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic         clk,
   input  logic         rst,
   seg_capture_if.slave bus
);
   typedef enum logic [1:0] {
      BLANK,
      SETTLE,
      LOCKED
   } state_t;

   localparam logic [7:0] THR = 8'(STABLE_CYCLES - 1);

   state_t           state, state_nx;
   logic [6:0]       seg_q;
   logic             digit_q;
   logic [6:0]       cand, cand_nx;
   logic [7:0]       stab, stab_nx;
   logic             accept;
   logic             legal;
   logic [3:0]       code;
   logic [3:0]       inc, dec;
   logic [3:0]       value;
   logic             valid;
   logic             update;
   logic             step_up;
   logic             step_down;
   logic             jump;
   logic             bad_glyph;
   logic [CNT_W-1:0] up_cnt;
   logic [CNT_W-1:0] down_cnt;

   assign inc = value + 4'd1;
   assign dec = value - 4'd1;

   // Register the raw display inputs every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q   <= '0;
         digit_q <= 1'b0;
      end else begin
         seg_q   <= bus.seg;
         digit_q <= bus.digit;
      end
   end

   // Stability tracker state, candidate and counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BLANK;
         cand  <= '0;
         stab  <= '0;
      end else begin
         state <= state_nx;
         cand  <= cand_nx;
         stab  <= stab_nx;
      end
   end

   // Next state; a blank always wins over acceptance.
   always_comb begin
      state_nx = state;
      cand_nx  = cand;
      stab_nx  = stab;
      accept   = 1'b0;
      unique case (state)
         BLANK: begin
            if (digit_q) begin
               cand_nx  = seg_q;
               stab_nx  = 8'd1;
               state_nx = SETTLE;
            end
         end
         SETTLE: begin
            if (!digit_q) begin
               stab_nx  = '0;
               state_nx = BLANK;
            end else if (seg_q != cand) begin
               cand_nx = seg_q;
               stab_nx = 8'd1;
            end else if (stab >= THR) begin
               accept   = 1'b1;
               state_nx = LOCKED;
            end else begin
               stab_nx = stab + 8'd1;
            end
         end
         LOCKED: begin
            if (!digit_q) begin
               stab_nx  = '0;
               state_nx = BLANK;
            end else if (seg_q != cand) begin
               cand_nx  = seg_q;
               stab_nx  = 8'd1;
               state_nx = SETTLE;
            end
         end
         default: state_nx = BLANK;
      endcase
   end

   // Map the candidate pattern back to its hex code.
   always_comb begin
      legal = 1'b1;
      code  = 4'h0;
      case (cand)
         7'h7E: code = 4'h0;
         7'h30: code = 4'h1;
         7'h6D: code = 4'h2;
         7'h79: code = 4'h3;
         7'h33: code = 4'h4;
         7'h5B: code = 4'h5;
         7'h5F: code = 4'h6;
         7'h70: code = 4'h7;
         7'h7F: code = 4'h8;
         7'h7B: code = 4'h9;
         7'h77: code = 4'hA;
         7'h1F: code = 4'hB;
         7'h4E: code = 4'hC;
         7'h3D: code = 4'hD;
         7'h4F: code = 4'hE;
         7'h47: code = 4'hF;
         default: legal = 1'b0;
      endcase
   end

   // Update value, event pulses and step counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         value     <= '0;
         valid     <= 1'b0;
         update    <= 1'b0;
         step_up   <= 1'b0;
         step_down <= 1'b0;
         jump      <= 1'b0;
         bad_glyph <= 1'b0;
         up_cnt    <= '0;
         down_cnt  <= '0;
      end else begin
         update    <= 1'b0;
         step_up   <= 1'b0;
         step_down <= 1'b0;
         jump      <= 1'b0;
         bad_glyph <= 1'b0;
         if (accept) begin
            if (!legal) begin
               bad_glyph <= 1'b1;
            end else if (!valid) begin
               value  <= code;
               valid  <= 1'b1;
               update <= 1'b1;
            end else if (code != value) begin
               value  <= code;
               update <= 1'b1;
               unique case (1'b1)
                  (code == inc): begin
                     step_up <= 1'b1;
                     if (up_cnt != '1)
                        up_cnt <= up_cnt + CNT_W'(1);
                  end
                  (code == dec): begin
                     step_down <= 1'b1;
                     if (down_cnt != '1)
                        down_cnt <= down_cnt + CNT_W'(1);
                  end
                  default: jump <= 1'b1;
               endcase
            end
         end
      end
   end

   assign bus.value     = value;
   assign bus.valid     = valid;
   assign bus.update    = update;
   assign bus.step_up   = step_up;
   assign bus.step_down = step_down;
   assign bus.jump      = jump;
   assign bus.bad_glyph = bad_glyph;
   assign bus.up_cnt    = up_cnt;
   assign bus.down_cnt  = down_cnt;
endmodule
